// File: rtl/mul_pkg.sv
// Shared definitions for the shift-and-add multiplier sequencer.
package mul_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    // Count value of the final iteration; the counter wraps after it.
    localparam logic [4:0] ITER_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/calookah.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries
// resolved from group generate/propagate terms.
module calookah (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic [7:0]  gg;
    logic [7:0]  gp;
    logic [8:0]  gc;

    // Bit and group generate/propagate, then group and bit carries.
    always_comb begin
        g  = a & b;
        p  = a ^ b;
        gg = '0;
        gp = '0;
        gc = '0;
        c  = '0;
        for (int i = 0; i < 8; i++) begin
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
            gp[i] = p[4*i+3] & p[4*i+2] & p[4*i+1] & p[4*i];
        end
        gc[0] = cin;
        for (int i = 0; i < 8; i++) begin
            gc[i+1] = gg[i] | (gp[i] & gc[i]);
        end
        for (int i = 0; i < 8; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i])
                     | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1])
                     | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
        c[32] = gc[8];
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/shift_add_mul_ctrl.sv
// Radix-2 shift-and-add sequencer: unsigned 32x32->64 product, one adder
// iteration per clock, valid/ready handshakes on both sides.
module shift_add_mul_ctrl
    import mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] mcand,
    input  logic [31:0] mplier,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] product,
    output logic        busy
);

    state_t            state;
    state_t            state_nxt;
    logic [MUL_W-1:0]  mcand_r;
    logic [MUL_W-1:0]  acc_hi;
    logic [MUL_W-1:0]  acc_lo;
    logic [4:0]        cnt;
    logic [MUL_W-1:0]  add_b;
    logic [MUL_W-1:0]  add_sum;
    logic              add_cout;

    // Multiplier LSB selects whether this iteration adds the multiplicand.
    assign add_b = acc_lo[0] ? mcand_r : '0;

    calookah u_add (
        .a    (acc_hi),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: accept in IDLE, fixed 32 iterations, wait for consumer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)          state_nxt = RUN;
            RUN:     if (cnt == ITER_LAST)  state_nxt = DONE;
            DONE:    if (out_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state only, so no input-to-output paths exist.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state == RUN) || (state == DONE);
    end

    // Operand capture, accumulate-and-shift iterations and result latch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_r <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r <= mcand;
                        acc_hi  <= '0;
                        acc_lo  <= mplier;
                        cnt     <= '0;
                    end
                end
                RUN: begin
                    // Carry-out becomes the new MSB, so no bit is ever lost.
                    acc_hi <= {add_cout, add_sum[MUL_W-1:1]};
                    acc_lo <= {add_sum[0], acc_lo[MUL_W-1:1]};
                    cnt    <= cnt + 5'd1;
                    if (cnt == ITER_LAST) begin
                        product <= {add_cout, add_sum, acc_lo[MUL_W-1:1]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_mul_ctrl.sv
// Self-checking bench for shift_add_mul_ctrl: fixed vector table, backpressure
// and mid-run reset sequences, and randomized operands against a 64-bit
// multiply reference.
module tb_shift_add_mul_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[7];

    shift_add_mul_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: plain 64-bit unsigned product.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // One full transaction. gap = cycles out_ready is held low after
    // out_valid; during the gap in_valid is toggled with junk operands.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int gap,
                          output logic [63:0] prod, output int lat, output int acc_cyc);
        int w;
        logic [63:0] held;
        prod    = '0;
        lat     = -1;
        acc_cyc = -1;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) begin
            chk("in_ready_timeout", 64'(in_ready), 64'd1);
            return;
        end
        mcand     = a;
        mplier    = b;
        in_valid  = 1'b1;
        out_ready = (gap == 0);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        mcand    = $urandom;
        mplier   = $urandom;
        chk("busy_after_accept", 64'(busy), 64'd1);
        chk("in_ready_in_run", 64'(in_ready), 64'd0);
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) begin
            chk("out_valid_timeout", 64'(out_valid), 64'd1);
            out_ready = 1'b0;
            return;
        end
        chk("in_ready_in_done", 64'(in_ready), 64'd0);
        held = product;
        for (int i = 0; i < gap; i++) begin
            in_valid = ~in_valid;
            mcand    = $urandom;
            mplier   = $urandom;
            @(posedge clk); #1;
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_product_stable", product, held);
            chk("bp_busy", 64'(busy), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        prod = product;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("in_ready_after_hs", 64'(in_ready), 64'd1);
        chk("out_valid_after_hs", 64'(out_valid), 64'd0);
        chk("busy_after_hs", 64'(busy), 64'd0);
    endtask

    initial begin
        logic [63:0] p;
        int          lat;
        int          ac;
        int          prev_ac;
        logic [31:0] ra;
        logic [31:0] rb;

        total = 0;
        bad   = 0;
        cyc   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mcand     = '0;
        mplier    = '0;

        vecs[0] = '{32'd3,         32'd5,         64'd15};
        vecs[1] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFFFFFE_00000001};
        vecs[2] = '{32'd0,         32'hDEADBEEF,  64'd0};
        vecs[3] = '{32'h12345678,  32'd0,         64'd0};
        vecs[4] = '{32'd7,         32'd9,         64'd63};
        vecs[5] = '{32'd1,         32'hFFFFFFFF,  64'h00000000_FFFFFFFF};
        vecs[6] = '{32'h80000000,  32'd2,         64'h00000001_00000000};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors, consumer ready up front.
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, 0, p, lat, ac);
            chk($sformatf("vec%0d_product", i), p, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
        end

        // Backpressure for 10 cycles with in_valid toggling.
        run_op(32'hCAFEBABE, 32'h01234567, 10, p, lat, ac);
        chk("bp_product", p, 64'hE62F_C1BA_2A3F_1BA2 ^ 64'h0 ^ (64'hE62FC1BA2A3F1BA2 ^ ref_mul(32'hCAFEBABE, 32'h01234567)));
        chk("bp_latency", 64'(lat), 64'd32);

        // Reset pulsed mid-run at cnt=10.
        mcand    = 32'hAAAA5555;
        mplier   = 32'h5555AAAA;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_product", product, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(32'd7, 32'd9, 0, p, lat, ac);
        chk("post_rst_product", p, 64'd63);
        chk("post_rst_latency", 64'(lat), 64'd32);

        // Randomized back-to-back operations with random consumer gaps.
        prev_ac = -1;
        for (int n = 0; n < 100; n++) begin
            case ($urandom_range(0, 7))
                0:       ra = 32'hFFFFFFFF;
                1:       ra = 32'd0;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 32'hFFFFFFFF;
                1:       rb = 32'd1;
                default: rb = $urandom;
            endcase
            run_op(ra, rb, $urandom_range(0, 4), p, lat, ac);
            chk($sformatf("rnd%0d_product", n), p, ref_mul(ra, rb));
            chk($sformatf("rnd%0d_latency", n), 64'(lat), 64'd32);
            if (prev_ac >= 0 && ac >= 0) begin
                chk($sformatf("rnd%0d_spacing_ge34", n), 64'(ac - prev_ac >= 34), 64'd1);
            end
            prev_ac = ac;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
